// File: rtl/riscv_pkg.sv
// Shared RV32I core types and constants used by the fetch path.
// Latency: n/a (types, constants and pure PC helpers only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Sequential word PC, wraps modulo 2^32.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

    // Instructions are word aligned; low address bits of a target are dropped.
    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with a registered head and a flush.
// Latency: a push becomes visible on head the cycle after it is written.
// Backpressure: none internally; the caller guarantees no push when full without a pop.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_ZERO = '0;
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

    fetch_entry_t       mem [DEPTH];
    fetch_entry_t       head_q;
    fetch_entry_t       head_d;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_ptr_nxt;
    logic [PTR_W:0]     cnt;

    assign rd_ptr_nxt = rd_ptr + 1'b1;

    // Head register tracks the entry that will be at the read pointer next cycle,
    // including the case where the slot being read is refilled in the same cycle.
    always_comb begin
        head_d = head_q;
        if (pop && (cnt > CNT_ONE)) begin
            head_d = mem[rd_ptr_nxt];
        end
        if (push && ((cnt == CNT_ZERO) || ((cnt == CNT_ONE) && pop))) begin
            head_d = push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            head_q <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            head_q <= head_d;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign count = cnt;
    assign head  = head_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited imem requests, queues responses for decode.
// Latency: response in cycle N is presented to decode in N+1; redirect in N empties the head in N+1.
// Backpressure: decode stall holds the head; requests stop once in-flight + queued reach DEPTH. Optional IF_PERF_CNT_EN adds perf counters.
module if_fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_bubble_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W+1)'(DEPTH);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  rsp_pc_q;
    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W-1:0] out_after_rsp;
    logic [CNT_W:0]   credit_used;
    logic             req_fire;
    logic             push;
    logic             pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    // A same-cycle pop deliberately does not return a credit: q_count is the registered occupancy.
    assign credit_used    = {1'b0, out_cnt} + {1'b0, q_count};
    assign imem_req_valid = rst_n && !redirect_valid && (credit_used < CREDIT_MAX);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push       = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
    assign pop        = if_valid && !stall;
    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

    assign out_after_rsp = imem_rsp_valid ? (out_cnt - 1'b1) : out_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight is stale, including a beat landing right now.
            pc_q     <= pc_align(redirect_pc);
            rsp_pc_q <= pc_align(redirect_pc);
            out_cnt  <= out_after_rsp;
            drop_cnt <= out_after_rsp;
        end else begin
            if (req_fire) begin
                pc_q <= pc_next(pc_q);
            end
            case ({req_fire, imem_rsp_valid})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
            if (imem_rsp_valid) begin
                if (drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end else begin
                    rsp_pc_q <= pc_next(rsp_pc_q);
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (q_count),
        .head       (head)
    );

    assign if_valid = (q_count != '0);
    assign if_pc    = head.pc;
    assign if_instr = head.instr;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (pop && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (!if_valid && !stall && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`else
    // Perf counters compiled out; the fetch datapath is identical either way.
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: in-order memory responder with programmable latency,
// hand-derived PC/instruction sequences for fetch, stall, redirect, wrap and imem back-pressure.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_lat = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // In-order memory: accepted request returns addr+0x100 mem_lat cycles later.
    always @(posedge clk) begin
        if (!rst_n) begin
            pend.delete();
        end else begin
            if (imem_rsp_valid && (pend.size() > 0)) begin
                void'(pend.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
            end
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst_n && (pend.size() > 0) && (pend[0].due <= cyc)) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= pend[0].addr + 32'h100;
        end else begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    // Wait (bounded) for the next consumed head, check it, then step past the pop.
    task automatic expect_next(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        int n = 0;
        while (!(if_valid && !stall) && (n < 30)) begin
            next_cycle();
            n++;
        end
        check({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
        check({tag, "_pc"}, if_pc, pc);
        check({tag, "_instr"}, if_instr, instr);
        next_cycle();
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        next_cycle();
        redirect_valid = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        stall          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_lat        = 1;
        repeat (3) next_cycle();

        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_if_valid", {31'b0, if_valid}, 32'd0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);

        // Sequential fetch with 1-cycle memory.
        rst_n = 1'b1;
        #1;
        check("c0_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("c0_req_addr", imem_req_addr, 32'h0);
        next_cycle();
        check("c1_if_valid", {31'b0, if_valid}, 32'd0);
        next_cycle();
        check("c2_if_valid", {31'b0, if_valid}, 32'd1);
        expect_next("seq0", 32'h0, 32'h100);
        expect_next("seq1", 32'h4, 32'h104);
        expect_next("seq2", 32'h8, 32'h108);
        expect_next("seq3", 32'hC, 32'h10C);

        // Stall: head 0x10 arrives and is held; credits run out.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            check("stall_valid", {31'b0, if_valid}, 32'd1);
            check("stall_pc", if_pc, 32'h10);
            check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        end
        stall = 1'b0;
        expect_next("rel0", 32'h10, 32'h110);
        expect_next("rel1", 32'h14, 32'h114);
        expect_next("rel2", 32'h18, 32'h118);

        // Fill the queue under stall, then redirect with stall held.
        stall   = 1'b1;
        mem_lat = 3;
        repeat (10) next_cycle();
        check("fill_pc", if_pc, 32'h1C);
        check("fill_req_valid", {31'b0, imem_req_valid}, 32'd0);
        pulse_redirect(32'h300);
        check("rdst_if_valid", {31'b0, if_valid}, 32'd0);
        check("rdst_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("rdst_req_addr", imem_req_addr, 32'h300);
        stall = 1'b0;
        next_cycle();
        check("infl_req_addr", imem_req_addr, 32'h304);
        next_cycle();
        check("infl_credit_out", {31'b0, imem_req_valid}, 32'd0);

        // Two requests in flight at 3-cycle latency, redirect to 0x40.
        pulse_redirect(32'h40);
        check("rd40_if_valid", {31'b0, if_valid}, 32'd0);
        check("rd40_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rd40_req_addr", imem_req_addr, 32'h40);
        expect_next("rd40_0", 32'h40, 32'h140);
        expect_next("rd40_1", 32'h44, 32'h144);

        // Response for 0x10 lands in the same cycle as a redirect to 0x80.
        stall   = 1'b1;
        mem_lat = 1;
        repeat (8) next_cycle();
        pulse_redirect(32'h10);
        check("sim_req_addr", imem_req_addr, 32'h10);
        check("sim_req_valid", {31'b0, imem_req_valid}, 32'd1);
        next_cycle();
        check("sim_req_addr2", imem_req_addr, 32'h14);
        pulse_redirect(32'h80);
        check("sim_if_valid", {31'b0, if_valid}, 32'd0);
        check("sim_req_addr3", imem_req_addr, 32'h80);
        stall = 1'b0;
        expect_next("sim0", 32'h80, 32'h180);
        expect_next("sim1", 32'h84, 32'h184);

        // Wrap-around; low target bits are ignored.
        pulse_redirect(32'hFFFF_FFFE);
        check("wrap_if_valid", {31'b0, if_valid}, 32'd0);
        check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        expect_next("wrap0", 32'hFFFF_FFFC, 32'h0000_00FC);
        expect_next("wrap1", 32'h0000_0000, 32'h0000_0100);
        expect_next("wrap2", 32'h0000_0004, 32'h0000_0104);

        // Memory back-pressure: ready 1,0,0,1 while decode is stalled.
        stall = 1'b1;
        repeat (6) next_cycle();
        pulse_redirect(32'h500);
        check("bp1_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("bp1_req_addr", imem_req_addr, 32'h500);
        next_cycle();
        check("bp2_req_addr", imem_req_addr, 32'h504);
        imem_req_ready = 1'b0;
        next_cycle();
        check("bp3_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("bp3_req_addr", imem_req_addr, 32'h504);
        next_cycle();
        check("bp4_req_addr", imem_req_addr, 32'h504);
        imem_req_ready = 1'b1;
        next_cycle();
        check("bp5_req_valid", {31'b0, imem_req_valid}, 32'd0);
        stall = 1'b0;
        expect_next("bp0", 32'h500, 32'h600);
        expect_next("bp1", 32'h504, 32'h604);
        expect_next("bp2", 32'h508, 32'h608);

        // Reset mid-operation clears immediately, then fetch restarts at RESET_PC.
        rst_n = 1'b0;
        #1;
        check("mrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("mrst_if_valid", {31'b0, if_valid}, 32'd0);
        check("mrst_req_addr", imem_req_addr, 32'h0);
        check("mrst_if_pc", if_pc, 32'h0);
        check("mrst_if_instr", if_instr, 32'h0);
        repeat (2) next_cycle();
        rst_n = 1'b1;
        #1;
        check("mrst_req_restart", {31'b0, imem_req_valid}, 32'd1);
        expect_next("mrst0", 32'h0, 32'h100);
        expect_next("mrst1", 32'h4, 32'h104);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
